// File: rtl/rf_line_assembler_if.sv
// rtl/rf_line_assembler_if.sv - channel sample input and summed-sample output stream bundle
interface rf_line_assembler_if;
  logic [11:0] Data_A;
  logic [11:0] Data_B;
  logic [11:0] Data_C;
  logic [11:0] Data_D;
  logic [11:0] Data_E;
  logic [11:0] Data_F;
  logic [11:0] Data_G;
  logic [11:0] Data_H;
  logic        in_valid;
  logic [14:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  // Source of channel samples and sink of the summed stream
  modport master (
    output Data_A, Data_B, Data_C, Data_D, Data_E, Data_F, Data_G, Data_H,
    output in_valid, out_ready,
    input  out_data, out_last, out_valid
  );

  // The line assembler itself
  modport slave (
    input  Data_A, Data_B, Data_C, Data_D, Data_E, Data_F, Data_G, Data_H,
    input  in_valid, out_ready,
    output out_data, out_last, out_valid
  );
endinterface

// File: rtl/rf_line_assembler.sv
// rtl/rf_line_assembler.sv - triggered line capture, 8-channel sum pipeline and show-ahead output FIFO
module rf_line_assembler #(
  parameter int LINE_LEN   = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_line_assembler_if.slave   bus,
  input  logic                 trigger,
  output logic                 busy,
  output logic                 overflow,
  output logic [15:0]          line_count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] sample_cnt;
  logic        accept;
  logic        at_last;
  logic        flush_done;

  logic        s1_valid;
  logic        s1_last;
  logic [13:0] s1_abcd;
  logic [13:0] s1_efgh;
  logic        s2_valid;
  logic        s2_last;
  logic [14:0] s2_sum;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        drop;
  logic [15:0] head;

  assign at_last = (sample_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: a trigger only counts in IDLE, capture ends on the last accepted sample
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger)            state_next = CAPTURE;
      CAPTURE: if (accept && at_last)  state_next = FLUSH;
      FLUSH:   if (flush_done)         state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // FSM outputs: accepted sample strobe, busy, and end-of-flush condition
  always_comb begin
    busy       = (state != IDLE);
    accept     = (state == CAPTURE) && bus.in_valid;
    flush_done = (state == FLUSH) && !s1_valid && !s2_valid && fifo_empty;
  end

  // Sample counter counts every accepted sample, dropped or not
  always_ff @(posedge clk) begin
    if (reset)                        sample_cnt <= '0;
    else if (state == IDLE && trigger) sample_cnt <= '0;
    else if (accept)                  sample_cnt <= sample_cnt + 16'd1;
  end

  // Completed-line counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset)           line_count <= '0;
    else if (flush_done) line_count <= line_count + 16'd1;
  end

  // Stage 1: two 4-channel partial sums plus the end-of-line tag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_abcd  <= '0;
      s1_efgh  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= at_last;
        s1_abcd <= 14'(bus.Data_A) + 14'(bus.Data_B) + 14'(bus.Data_C) + 14'(bus.Data_D);
        s1_efgh <= 14'(bus.Data_E) + 14'(bus.Data_F) + 14'(bus.Data_G) + 14'(bus.Data_H);
      end
    end
  end

  // Stage 2: full 15-bit sum, wide enough for 8 x 4095
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_sum  <= 15'(s1_abcd) + 15'(s1_efgh);
      end
    end
  end

  // FIFO occupancy; a concurrent pop frees the slot so a write into a full FIFO is not a drop
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = fill[AW];
  assign pop        = !fifo_empty && bus.out_ready;
  assign push       = s2_valid && (!fifo_full || pop);
  assign drop       = s2_valid && fifo_full && !pop;

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage, entries are {last, sum}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s2_last, s2_sum};
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // Show-ahead head; outputs forced to zero when empty
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? 15'd0 : head[14:0];
  assign bus.out_last  = !fifo_empty && head[15];

endmodule

// File: tb/tb_rf_line_assembler.sv
// tb/tb_rf_line_assembler.sv - directed self-checking bench for rf_line_assembler
module tb_rf_line_assembler;
  localparam int LINE_LEN   = 512;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        busy;
  logic        overflow;
  logic [15:0] line_count;

  rf_line_assembler_if bus ();

  rf_line_assembler #(.LINE_LEN(LINE_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .trigger    (trigger),
    .busy       (busy),
    .overflow   (overflow),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  bit lat_chk = 1'b0;
  int n_out   = 0;
  int m_d, m_l, m_c;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_k(input int k);
    bus.Data_A = 12'(k);     bus.Data_E = 12'(k);
    bus.Data_B = 12'(k + 1); bus.Data_F = 12'(k + 1);
    bus.Data_C = 12'(k + 2); bus.Data_G = 12'(k + 2);
    bus.Data_D = 12'(k + 3); bus.Data_H = 12'(k + 3);
  endtask

  task automatic set_flat(input int v);
    bus.Data_A = 12'(v); bus.Data_B = 12'(v); bus.Data_C = 12'(v); bus.Data_D = 12'(v);
    bus.Data_E = 12'(v); bus.Data_F = 12'(v); bus.Data_G = 12'(v); bus.Data_H = 12'(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int data, input int last);
    q_data.push_back(data);
    q_last.push_back(last);
    q_cyc.push_back(cyc);
  endtask

  task automatic clear_exp();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic fire_trigger();
    step();
    trigger = 1'b1;
    bus.in_valid = 1'b1;
    set_k(2000);
  endtask

  task automatic send(input int k, input int idx);
    step();
    trigger = 1'b0;
    set_k(k);
    bus.in_valid = 1'b1;
    push_exp(8 * k + 12, (idx == LINE_LEN - 1) ? 1 : 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    step();
    trigger = 1'b0;
    bus.in_valid = 1'b0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check(tag, int'(busy), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    trigger = 1'b0;
    bus.in_valid = 1'b0;
    clear_exp();
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Output scoreboard: every accepted head must match the next expected entry
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (q_data.size() == 0) begin
        check("extra_out", int'(bus.out_data), -1);
      end else begin
        m_d = q_data.pop_front();
        m_l = q_last.pop_front();
        m_c = q_cyc.pop_front();
        check("out_data", int'(bus.out_data), m_d);
        check("out_last", int'(bus.out_last), m_l);
        if (lat_chk) check("latency", cyc - m_c, 3);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_k(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_line_count", int'(line_count), 0);

    // Generator line, no backpressure
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    n_out = 0;
    fire_trigger();
    for (int k = 0; k < LINE_LEN; k++) begin
      send(k, k);
      if (k == 0) check("busy_capture", int'(busy), 1);
    end
    wait_idle("t1_flush_timeout");
    check("t1_line_count", int'(line_count), 1);
    check("t1_overflow", int'(overflow), 0);
    check("t1_drained", q_data.size(), 0);
    check("t1_n_out", n_out, 512);

    // Backpressure: samples 16..19 dropped, sample 20 written alongside a pop
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    n_out = 0;
    fire_trigger();
    for (int i = 0; i < LINE_LEN; i++) begin
      step();
      trigger = 1'b0;
      set_k(i);
      bus.in_valid = 1'b1;
      if (i < 16 || i >= 20) push_exp(8 * i + 12, (i == LINE_LEN - 1) ? 1 : 0);
      if (i == 22) bus.out_ready = 1'b1;
      if (i < 22) begin
        @(negedge clk);
        check("bp_overflow", int'(overflow), (i >= 19) ? 1 : 0);
        check("bp_out_valid", int'(bus.out_valid), (i >= 3) ? 1 : 0);
        if (i >= 3) check("bp_head", int'(bus.out_data), 12);
      end
    end
    wait_idle("t2_flush_timeout");
    check("t2_line_count", int'(line_count), 2);
    check("t2_overflow_sticky", int'(overflow), 1);
    check("t2_drained", q_data.size(), 0);
    check("t2_n_out", n_out, 508);

    // in_valid gaps with re-triggers during CAPTURE and FLUSH
    do_reset();
    @(negedge clk);
    check("t3_rst_overflow", int'(overflow), 0);
    check("t3_rst_line_count", int'(line_count), 0);
    lat_chk = 1'b1;
    bus.out_ready = 1'b1;
    n_out = 0;
    fire_trigger();
    for (int j = 0; j < 2 * LINE_LEN; j++) begin
      step();
      trigger = (j == 100);
      if (j % 2 == 0) begin
        set_k(j / 2);
        bus.in_valid = 1'b1;
        push_exp(8 * (j / 2) + 12, (j / 2 == LINE_LEN - 1) ? 1 : 0);
      end else begin
        set_k(3000);
        bus.in_valid = 1'b0;
      end
    end
    begin
      int n = 0;
      forever begin
        step();
        bus.in_valid = 1'b1;
        set_k(1500);
        if (!busy || n >= 200) begin
          trigger = 1'b0;
          break;
        end
        trigger = 1'b1;
        n++;
      end
    end
    check("t3_flush_timeout", int'(busy), 0);
    repeat (10) step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t3_busy_after", int'(busy), 0);
    check("t3_line_count", int'(line_count), 1);
    check("t3_drained", q_data.size(), 0);
    check("t3_n_out", n_out, 512);

    // Reset mid-line with a non-empty FIFO
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    fire_trigger();
    for (int k = 0; k < 100; k++) send(k, k);
    @(negedge clk);
    check("t4_pre_out_valid", int'(bus.out_valid), 1);
    check("t4_pre_overflow", int'(overflow), 1);
    step();
    reset = 1'b1;
    set_k(100);
    bus.in_valid = 1'b1;
    clear_exp();
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_out_valid", int'(bus.out_valid), 0);
    check("t4_out_data", int'(bus.out_data), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_line_count", int'(line_count), 0);
    check("t4_overflow", int'(overflow), 0);
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    n_out = 0;
    fire_trigger();
    for (int i = 0; i < LINE_LEN; i++) send(101 + i, i);
    wait_idle("t4_flush_timeout");
    check("t4_line_count_after", int'(line_count), 1);
    check("t4_overflow_after", int'(overflow), 0);
    check("t4_drained", q_data.size(), 0);
    check("t4_n_out", n_out, 512);

    // Full-scale input
    n_out = 0;
    fire_trigger();
    for (int i = 0; i < LINE_LEN; i++) begin
      step();
      trigger = 1'b0;
      set_flat(4095);
      bus.in_valid = 1'b1;
      push_exp(32760, (i == LINE_LEN - 1) ? 1 : 0);
    end
    wait_idle("t5_flush_timeout");
    check("t5_line_count", int'(line_count), 2);
    check("t5_overflow", int'(overflow), 0);
    check("t5_drained", q_data.size(), 0);
    check("t5_n_out", n_out, 512);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/rf_line_assembler.md
# rf_line_assembler

Downstream consumer of the 8-channel, 12-bit sample stream (Data_A..Data_H) produced by the channel data source. On a line trigger it captures exactly LINE_LEN consecutive valid samples. Each sample's 8 channels are summed in a 2-stage pipeline. The results are buffered in a FIFO and streamed out over a valid/ready interface, with a last marker on the final sample of each line. This stage sits between the front-end channel data and the line-based processing/readout path.

## Interface

- LINE_LEN, 512: valid samples captured per line; range 2..65535.
- FIFO_DEPTH, 16: output FIFO entries; power of two, ≥4.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Data_A..Data_H  in  12 each  unsigned channel samples.
- in_valid  in  1  Data_A..Data_H valid this cycle.
- trigger  in  1  start-of-line request; one-cycle pulse, honoured only in IDLE.
- out_data  out  15  unsigned 8-channel sum.
- out_last  out  1  qualifies out_data as the last sample of a line.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head when out_valid & out_ready.
- busy  out  1  high in CAPTURE or FLUSH.
- overflow  out  1  sticky; set on any sample dropped due to a full FIFO.
- line_count  out  16  completed lines, modulo 2^16.

## Operation

- Reset values: FSM=IDLE, sample counter=0, FIFO empty, pipeline valids=0, out_valid=0, out_data=0, out_last=0, busy=0, overflow=0, line_count=0.
- Reset mid-line discards the pipeline and FIFO contents. No partial line is emitted afterwards.
- IDLE:
  - trigger=1 → CAPTURE and clear the sample counter.
  - in_valid is ignored.
- CAPTURE: each cycle with in_valid=1 is an accepted sample.
  - Stage 1 registers two partial sums, A+B+C+D and E+F+G+H, 14 bits each, zero-extended.
  - Stage 2 registers their 15-bit sum. The full-scale value 32760 cannot overflow.
  - The tag last=(counter==LINE_LEN-1) travels with the sample.
  - The counter increments on every accepted sample, including dropped ones.
  - On the accepted sample with counter==LINE_LEN-1 → FLUSH.
- FLUSH: wait until both pipeline stages are empty and the FIFO is empty, then go to IDLE and increment line_count (wraps 65535→0).
- trigger in CAPTURE or FLUSH: ignored, no queuing. A trigger in the same cycle as the FLUSH→IDLE transition is also ignored.
- in_valid in the cycle trigger is seen in IDLE: not captured. Capture begins the following cycle.
- FIFO write:
  - The stage-2 output is written when its valid bit is set and the FIFO is not full.
  - If the FIFO is full, the sample is dropped and overflow is set.
  - A simultaneous read frees the slot: a write with a concurrent pop when full is not a drop.
- The FIFO is show-ahead. out_data/out_last reflect the head entry. out_data=0 and out_last=0 when empty.
- A dropped last sample means no out_last for that line. The line still completes via FLUSH.
- out_data/out_last must stay stable while out_valid=1 and out_ready=0.

## Timing

- Latency with an empty FIFO:
  - A sample presented with in_valid in cycle t is registered in stage 1 at the end of t.
  - It is registered in stage 2 at the end of t+1.
  - It is written to the FIFO at the end of t+2.
  - out_valid=1 with its data in cycle t+3.
- Throughput: one sample per clock in both directions with no stalls.
- Capture duration: the FSM leaves CAPTURE on the edge ending the LINE_LEN-th accepted cycle.
- line_count and busy=0 update on the FLUSH→IDLE edge. This occurs at the earliest one cycle after the last FIFO pop.
- overflow is set on the edge of the drop and stays set until reset.

## Test plan

- Generator pattern: Data_A=Data_E=k, B=F=k+1, C=G=k+2, D=H=k+3, with k incrementing 0..511 each cycle and in_valid=1. Stimulus: trigger with out_ready=1 → 512 outputs, 12, 20, …, 4100 (8k+12), each 3 cycles after input. out_last only on 4100. line_count=1, overflow=0.
- Full-scale input: all channels=4095 for LINE_LEN=4 → four outputs of 32760, no wrap.
- Backpressure with FIFO_DEPTH=16: hold out_ready=0 for 20 accepted samples → out_valid held, head stable at 12, overflow=1 after the 17th write attempt. After release, exactly 16 values drain in order 12..132.
- in_valid gaps: toggle in_valid 1/0 → exactly LINE_LEN outputs, with gaps preserved. A re-trigger during CAPTURE and during FLUSH is ignored, so line_count rises by exactly 1.
- Reset mid-line: assert reset at sample 100 with FIFO non-empty → next cycle out_valid=0, busy=0, line_count=0, overflow=0. A new trigger yields a clean line starting at the current k.
- Wrap: 65536 lines with LINE_LEN=2 → line_count returns to 0.
